// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states, read-return owner tags, default sizes.
package mem_arb_pkg;
    localparam int DEF_AW       = 6;
    localparam int DEF_DW       = 16;
    localparam int DEF_LOCK_MAX = 64;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PROC = 2'd1,
        HOST = 2'd2
    } owner_t;

    // At most one of the inputs is high because only one access is accepted per cycle.
    function automatic owner_t read_owner(input logic p_rd, input logic h_rd);
        if (p_rd) return PROC;
        if (h_rd) return HOST;
        return NONE;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// One master port of the RAM arbiter: request/write qualifiers in, grant and read return out.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] q;

    modport master (output req, we, lock, addr, din, input gnt, rvalid, q);
    modport slave  (input req, we, lock, addr, din, output gnt, rvalid, q);
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin picker: last = index of the requester served most recently.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pick
            // Win when alone, or on a tie when the other side was served last.
            assign gnt[gi] = req[gi] & (~req[1-gi] | (last != 1'(gi)));
        end
    endgenerate
endmodule

// File: rtl/mem_arbiter.sv
// Shares one 64x16 registered-address RAM between processor (p) and host (h) ports.
// Optional host lock for burst loads is built when MEM_ARB_LOCK_EN is defined.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clock,
    input  logic          resetN,
    mem_arbiter_if.slave  p,
    mem_arbiter_if.slave  h,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_w,
    input  logic [DW-1:0] ram_q,
    output logic          lock_err
);
    logic       locked;
    logic       last_reg;   // 1 = host was served last
    owner_t     owner_reg;
    logic [1:0] rr_gnt;
    logic       p_acc;
    logic       h_acc;

    arb_rr2 u_rr (
        .req  ({h.req, p.req}),
        .last (last_reg),
        .gnt  (rr_gnt)
    );

    always_comb begin
        p_acc = 1'b0;
        h_acc = 1'b0;
        if (resetN) begin
            if (locked) begin
                h_acc = h.req;
            end else begin
                p_acc = rr_gnt[0];
                h_acc = rr_gnt[1];
            end
        end
    end

    assign p.gnt = p_acc;
    assign h.gnt = h_acc;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_w    = 1'b0;
        if (p_acc) begin
            ram_addr = p.addr;
            ram_din  = p.din;
            ram_w    = p.we;
        end else if (h_acc) begin
            ram_addr = h.addr;
            ram_din  = h.din;
            ram_w    = h.we;
        end
    end

    // Locking always starts with a host accept and only the host is served while locked,
    // so last_reg already points at the host whenever the lock ends.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            last_reg  <= 1'b1;
            owner_reg <= NONE;
        end else begin
            if (p_acc) begin
                last_reg <= 1'b0;
            end else if (h_acc) begin
                last_reg <= 1'b1;
            end
            owner_reg <= read_owner(p_acc & ~p.we, h_acc & ~h.we);
        end
    end

    assign p.rvalid = (owner_reg == PROC);
    assign h.rvalid = (owner_reg == HOST);
    assign p.q      = p.rvalid ? ram_q : '0;
    assign h.q      = h.rvalid ? ram_q : '0;

`ifdef MEM_ARB_LOCK_EN
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    state_t        state_reg;
    logic [CW-1:0] lock_cnt_reg;
    logic          lock_err_reg;
    logic          unused_lock;

    // Timeout is checked before the host's own unlock so a simultaneous relock still releases.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg    <= ARB;
            lock_cnt_reg <= '0;
            lock_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (h_acc && h.lock) begin
                        state_reg    <= LOCKED;
                        lock_cnt_reg <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_cnt_reg == CW'(LOCK_MAX - 1)) begin
                        state_reg    <= ARB;
                        lock_err_reg <= 1'b1;
                    end else if (h_acc && !h.lock) begin
                        state_reg <= ARB;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    assign locked      = (state_reg == LOCKED);
    assign lock_err    = lock_err_reg;
    assign unused_lock = p.lock;
`else
    logic unused_lock;

    assign locked      = 1'b0;
    assign lock_err    = 1'b0;
    assign unused_lock = &{1'b0, p.lock, h.lock};
`endif
endmodule
